// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for a single 2-input gate: walks {a,b} through 00..11,
// compares y_i against TRUTH and reports pass/error count/first failure.
// Define GATE_BIST_STOP_ON_FAIL_EN to end the pass at the first mismatch.
module gate_bist_ctrl #(
  parameter logic [3:0] TRUTH  = 4'b0111,
  parameter int         SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  input  logic       y_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] fail_vec,
  output logic       fail_got
);

  // state | meaning
  // IDLE  | waiting for the first start after reset
  // APPLY | driving a vector, settling, then comparing y_i
  // DONE  | results valid; start reruns the pass
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [3:0] SETTLE_V = SETTLE[3:0];

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic       a_nxt, b_nxt, done_nxt, pass_nxt, fail_got_nxt;
  logic [2:0] err_nxt;
  logic [1:0] fail_vec_nxt;
  logic [1:0] vec;
  logic       mismatch;
  logic       finish;

  assign vec      = {a_o, b_o};
  assign mismatch = (y_i != TRUTH[vec]);
  assign busy     = (state == APPLY);

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    wait_nxt     = wait_cnt;
    a_nxt        = a_o;
    b_nxt        = b_o;
    done_nxt     = done;
    pass_nxt     = pass;
    err_nxt      = err_cnt;
    fail_vec_nxt = fail_vec;
    fail_got_nxt = fail_got;
    finish       = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt    = APPLY;
          idx_nxt      = 2'd0;
          a_nxt        = 1'b0;
          b_nxt        = 1'b0;
          wait_nxt     = SETTLE_V;
          err_nxt      = 3'd0;
          fail_vec_nxt = 2'd0;
          fail_got_nxt = 1'b0;
          done_nxt     = 1'b0;
          pass_nxt     = 1'b0;
        end
      end
      APPLY: begin
        if (wait_cnt != 4'd0) begin
          wait_nxt = wait_cnt - 4'd1;
        end else begin
          if (mismatch) begin
            if (err_cnt != 3'd4) err_nxt = err_cnt + 3'd1;
            if (err_cnt == 3'd0) begin
              fail_vec_nxt = vec;
              fail_got_nxt = y_i;
            end
          end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
          finish = mismatch || (idx == 2'd3);
`else
          finish = (idx == 2'd3);
`endif
          if (finish) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == 3'd0);
            a_nxt     = 1'b0;
            b_nxt     = 1'b0;
          end else begin
            idx_nxt          = idx + 2'd1;
            {a_nxt, b_nxt}   = idx + 2'd1;
            wait_nxt         = SETTLE_V;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 2'd0;
      wait_cnt <= 4'd0;
      a_o      <= 1'b0;
      b_o      <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= 3'd0;
      fail_vec <= 2'd0;
      fail_got <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      wait_cnt <= wait_nxt;
      a_o      <= a_nxt;
      b_o      <= b_nxt;
      done     <= done_nxt;
      pass     <= pass_nxt;
      err_cnt  <= err_nxt;
      fail_vec <= fail_vec_nxt;
      fail_got <= fail_got_nxt;
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: a default NAND instance driven by a
// selectable gate model, and an AND instance with zero settle time.
module tb_gate_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1;
  logic       a0, b0, y0, busy0, done0, pass0, fgot0;
  logic [2:0] err0;
  logic [1:0] fvec0;
  logic       a1, b1, y1, busy1, done1, pass1, fgot1;
  logic [2:0] err1;
  logic [1:0] fvec1;
  int         mode;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  // gate model: 0 ideal NAND, 1 stuck-at-1, 2 stuck-at-0
  always_comb begin
    case (mode)
      0:       y0 = ~(a0 & b0);
      1:       y0 = 1'b1;
      default: y0 = 1'b0;
    endcase
  end
  assign y1 = a1 & b1;

  gate_bist_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_o(a0), .b_o(b0), .y_i(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .fail_vec(fvec0), .fail_got(fgot0)
  );

  gate_bist_ctrl #(.TRUTH(4'b1000), .SETTLE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_o(a1), .b_o(b1), .y_i(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_vec(fvec1), .fail_got(fgot1)
  );

  typedef struct {
    int mode;
    int cyc;
    int pass;
    int err;
    int fvec;
    int fgot;
  } vec_t;

  vec_t tbl[3];
  vec_t sb[$];
  int   ab_q[$];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_a"}, a0, 0);
    chk({tag, "_b"}, b0, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_pass"}, pass0, 0);
    chk({tag, "_err"}, err0, 0);
    chk({tag, "_fvec"}, fvec0, 0);
    chk({tag, "_fgot"}, fgot0, 0);
  endtask

  // called at a negedge just after the start edge; counts busy cycles until done
  task automatic wait_done0(input int poke, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (done0) begin
        ok = 1'b1;
        break;
      end
      if (busy0) cyc++;
      start0 = (poke >= 0 && cyc == poke);
      @(negedge clk);
    end
    start0 = 1'b0;
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic run_pass0(input int m, input int poke, output int cyc);
    bit ok;
    mode   = m;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0(poke, cyc, ok);
  endtask

  task automatic check_result(input string tag, input int cyc);
    vec_t e;
    e = sb.pop_front();
    chk({tag, "_cyc"}, cyc, e.cyc);
    chk({tag, "_done"}, done0, 1);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_pass"}, pass0, e.pass);
    chk({tag, "_err"}, err0, e.err);
    chk({tag, "_fvec"}, fvec0, e.fvec);
    chk({tag, "_fgot"}, fgot0, e.fgot);
    chk({tag, "_ab"}, {a0, b0}, 0);
  endtask

  initial begin
    int  cyc;
    bit  ok;
    int  exp_ab;

    tbl[0] = '{mode: 0, cyc: 8, pass: 1, err: 0, fvec: 0, fgot: 0};
    tbl[1] = '{mode: 1, cyc: 8, pass: 0, err: 1, fvec: 3, fgot: 1};
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    tbl[2] = '{mode: 2, cyc: 2, pass: 0, err: 1, fvec: 0, fgot: 0};
`else
    tbl[2] = '{mode: 2, cyc: 8, pass: 0, err: 3, fvec: 0, fgot: 0};
`endif

    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    repeat (2) @(negedge clk);
    chk_zero0("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      sb.push_back(tbl[i]);
      run_pass0(tbl[i].mode, -1, cyc);
      check_result($sformatf("vec%0d", i), cyc);
    end

    // start pulsed mid-pass must not stretch or restart it
    sb.push_back(tbl[0]);
    run_pass0(0, 3, cyc);
    check_result("poke", cyc);

    // stuck-at-1 leaves nonzero results; a start in DONE must clear them
    sb.push_back(tbl[1]);
    run_pass0(1, -1, cyc);
    check_result("pre_rerun", cyc);
    mode   = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("rerun_done_clr", done0, 0);
    chk("rerun_err_clr", err0, 0);
    chk("rerun_fvec_clr", fvec0, 0);
    chk("rerun_fgot_clr", fgot0, 0);
    chk("rerun_busy", busy0, 1);
    sb.push_back(tbl[0]);
    wait_done0(-1, cyc, ok);
    check_result("rerun", cyc);

    // AND gate, zero settle: one compare per cycle, vectors in order
    for (int v = 0; v < 4; v++) ab_q.push_back(v);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (done1) begin
        ok = 1'b1;
        break;
      end
      if (busy1) begin
        cyc++;
        exp_ab = (ab_q.size() > 0) ? ab_q.pop_front() : -1;
        chk($sformatf("and_ab%0d", cyc), {a1, b1}, exp_ab);
      end
      @(negedge clk);
    end
    if (!ok) chk("and_timeout", 0, 1);
    chk("and_cyc", cyc, 4);
    chk("and_pass", pass1, 1);
    chk("and_err", err1, 0);

    // reset during vector 2 aborts without a done
    mode   = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_vec", {a0, b0}, 2);
    rst_n = 1'b0;
    #1;
    chk_zero0("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", i), {busy0, done0}, 0);
    end
    sb.push_back(tbl[0]);
    run_pass0(0, -1, cyc);
    check_result("post_rst", cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
